pe_add_arbiter: RTL
===================

Name: pe_add_arbiter

Overview:
- Round-robin arbiter that shares one vector add/sub processing element (PE) among NREQ requesters.
- The PE has one registered cycle of latency: c <= a ± b per lane, ctrl 0 = add, 1 = subtract, async active-low reset.
- The block drives the PE operands and opcode, tracks the in-flight operation, and captures each result into a 2-entry response FIFO tagged with the requester id.
- Credit-based issue guarantees no result is lost under response backpressure.

Parameters:
- NREQ, 4, number of requesters (≥2).
- matsize, 16, lanes per vector.
- wordsize, 32, bits per lane.
- IDW, $clog2(NREQ), requester id width (derived).

Ports:
- clk  in  1  clock.
- RESET  in  1  asynchronous reset, active-low.
- req_valid  in  NREQ  per-requester operation valid.
- req_ready  out  NREQ  per-requester accept; one-hot or zero.
- req_op  in  NREQ  per-requester opcode: 0 = add, 1 = subtract.
- req_a  in  NREQ x matsize x wordsize  operand A per requester.
- req_b  in  NREQ x matsize x wordsize  operand B per requester.
- pe_a  out  matsize x wordsize  PE operand A.
- pe_b  out  matsize x wordsize  PE operand B.
- pe_ctrl  out  1  PE add/sub select.
- pe_c  in  matsize x wordsize  PE registered result.
- rsp_valid  out  1  response FIFO head valid.
- rsp_ready  in  1  response consumer accept.
- rsp_id  out  IDW  requester id of the head entry.
- rsp_data  out  matsize x wordsize  result of the head entry.
- busy  out  1  in-flight op or FIFO non-empty.
- grant_cnt  out  32  total accepted ops; wraps at 2^32.

Behaviour:
- Reset (RESET low, async):
  - rr_ptr=0, inflight=0, FIFO empty, grant_cnt=0.
  - rsp_valid=0, rsp_id=0, rsp_data=0, busy=0.
  - req_ready=0; pe_a/pe_b/pe_ctrl=0.
  - An in-flight result is discarded. Reset is shared with the PE.
- Credit:
  - pop = rsp_valid & rsp_ready.
  - issue_ok = (fifo_count + inflight - pop) < 2.
- Arbitration (combinational, per cycle):
  - Winner = first i with req_valid[i], scanning rr_ptr, rr_ptr+1, ... mod NREQ.
  - req_ready[winner] = issue_ok; all other bits 0.
  - req_ready may depend combinationally on req_valid.
  - Requesters hold valid and operands stable until accepted.
- Issue (accept = any req_valid & issue_ok):
  - pe_a=req_a[w], pe_b=req_b[w], pe_ctrl=req_op[w] in the same cycle, combinationally.
  - When no accept occurs, pe_* drive 0.
  - On the clock edge: inflight<=1, inflight_id<=w, rr_ptr<=(w+1) mod NREQ, grant_cnt++.
  - With no accept: inflight<=0, rr_ptr unchanged.
- Capture:
  - In the cycle after issue, pe_c holds the result.
  - At the end of that cycle, {inflight_id, pe_c} is pushed into the FIFO.
  - Latency: accept at cycle t -> rsp_valid at cycle t+2 when the FIFO was empty.
- FIFO:
  - 2 entries, in order; head on rsp_*.
  - Push and pop may occur in the same cycle; count is unchanged.
  - Overflow is impossible by the credit rule.
  - rsp_data/rsp_id hold stable while rsp_valid & !rsp_ready.
- Throughput:
  - One op per cycle sustained when rsp_ready=1.
  - With rsp_ready=0: at most 2 ops accepted, then req_ready=0 until a pop.
- Arithmetic: per-lane modulo 2^wordsize, done by the PE; this block does not alter data.
- busy = inflight | (fifo_count != 0).

Test Plan:
- Single add: req_valid[2]=1, a lanes=5, b lanes=3, op=0, rsp_ready=1 -> req_ready=4'b0100 at cycle t; rsp_valid at t+2 with rsp_id=2, all lanes 8; grant_cnt=1.
- Subtract wrap: requester 0, a=0, b=1, op=1 -> all lanes 32'hFFFFFFFF, rsp_id=0.
- Fairness: all 4 valid continuously, rsp_ready=1 -> grants 0,1,2,3,0,1 on consecutive cycles; responses back-to-back in the same id order with correct per-requester results.
- Backpressure: requester 1 issues continuously, rsp_ready=0 -> exactly 2 accepts, then req_ready=0 and busy=1. Raise rsp_ready -> the held head pops first, then accepts resume at one per cycle. No result is lost or reordered.
- Credit boundary: FIFO holds 1 entry, 1 op in flight, rsp_ready=1, requester 3 valid -> accept occurs that cycle (push/pop simultaneous), fifo_count stays consistent.
- Reset mid-flight: assert RESET the cycle after an accept -> rsp_valid=0, busy=0, grant_cnt=0, rr_ptr=0. After release, the next accept with all requesters valid grants requester 0.

Source files
------------

// File: rtl/pe_add_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : pe_add_arbiter
// Purpose  : Round-robin sharing of one registered add/sub PE, with a credited
//            2-entry id-tagged response FIFO.
// Revision : 1.0
// ============================================================================
module pe_add_arbiter #(
  parameter int NREQ     = 4,
  parameter int matsize  = 16,
  parameter int wordsize = 32,
  parameter int IDW      = $clog2(NREQ)
) (
  input  logic                                     clk,
  input  logic                                     RESET,
  input  logic [NREQ-1:0]                          req_valid,
  output logic [NREQ-1:0]                          req_ready,
  input  logic [NREQ-1:0]                          req_op,
  input  logic [NREQ-1:0][matsize-1:0][wordsize-1:0] req_a,
  input  logic [NREQ-1:0][matsize-1:0][wordsize-1:0] req_b,
  output logic [matsize-1:0][wordsize-1:0]         pe_a,
  output logic [matsize-1:0][wordsize-1:0]         pe_b,
  output logic                                     pe_ctrl,
  input  logic [matsize-1:0][wordsize-1:0]         pe_c,
  output logic                                     rsp_valid,
  input  logic                                     rsp_ready,
  output logic [IDW-1:0]                           rsp_id,
  output logic [matsize-1:0][wordsize-1:0]         rsp_data,
  output logic                                     busy,
  output logic [31:0]                              grant_cnt
);

  typedef logic [matsize-1:0][wordsize-1:0] vec_t;

  logic [IDW-1:0] r_rr_ptr;
  logic [IDW-1:0] r_inflight_id;
  logic           r_inflight;
  logic [31:0]    r_grant_cnt;
  logic [1:0]     r_count;
  logic           r_wr_ptr;
  logic           r_rd_ptr;
  vec_t           r_mem_data [2];
  logic [IDW-1:0] r_mem_id   [2];

  logic [IDW-1:0] w_win;
  logic [IDW-1:0] w_next_ptr;
  logic           w_found;
  logic           w_accept;
  logic           w_pop;
  logic           w_push;
  logic [2:0]     w_credit;
  logic           w_issue_ok;
  int             w_idx;

  assign rsp_valid  = (r_count != 2'd0);
  assign w_pop      = rsp_valid & rsp_ready;
  assign w_push     = r_inflight;
  // A slot freed by this cycle's pop may be reused by this cycle's issue.
  assign w_credit   = {1'b0, r_count} + {2'b00, r_inflight} - {2'b00, w_pop};
  assign w_issue_ok = (w_credit < 3'd2);

  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    w_idx   = 0;
    for (int k = 0; k < NREQ; k++) begin
      w_idx = (int'(r_rr_ptr) + k) % NREQ;
      if (!w_found && req_valid[w_idx]) begin
        w_found = 1'b1;
        w_win   = w_idx[IDW-1:0];
      end
    end
  end

  // Gated by RESET so nothing is offered to requesters while held in reset.
  assign w_accept   = w_found & w_issue_ok & RESET;
  assign w_next_ptr = (w_win == IDW'(NREQ - 1)) ? '0 : w_win + IDW'(1);

  always_comb begin
    req_ready = '0;
    pe_a      = '0;
    pe_b      = '0;
    pe_ctrl   = 1'b0;
    if (w_accept) begin
      req_ready[w_win] = 1'b1;
      pe_a             = req_a[w_win];
      pe_b             = req_b[w_win];
      pe_ctrl          = req_op[w_win];
    end
  end

  always_ff @(posedge clk or negedge RESET) begin
    if (!RESET) begin
      r_rr_ptr      <= '0;
      r_inflight    <= 1'b0;
      r_inflight_id <= '0;
      r_grant_cnt   <= '0;
    end else begin
      r_inflight <= w_accept;
      if (w_accept) begin
        r_inflight_id <= w_win;
        r_rr_ptr      <= w_next_ptr;
        r_grant_cnt   <= r_grant_cnt + 32'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge RESET) begin
    if (!RESET) begin
      r_count  <= 2'd0;
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      for (int e = 0; e < 2; e++) begin
        r_mem_data[e] <= '0;
        r_mem_id[e]   <= '0;
      end
    end else begin
      if (w_push) begin
        r_mem_data[r_wr_ptr] <= pe_c;
        r_mem_id[r_wr_ptr]   <= r_inflight_id;
        r_wr_ptr             <= ~r_wr_ptr;
      end
      if (w_pop) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign rsp_data  = r_mem_data[r_rd_ptr];
  assign rsp_id    = r_mem_id[r_rd_ptr];
  assign busy      = r_inflight | (r_count != 2'd0);
  assign grant_cnt = r_grant_cnt;

endmodule
`default_nettype wire
